// File: rtl/lane_rr_arbiter.sv
// lane_rr_arbiter: shares one registered output lane among requesters a, b, c.
// A winner keeps the lane until the last beat of its packet is accepted; the
// priority pointer advances past the winner only when a packet completes.
//
// Handshake: a beat moves when valid && ready are both high on a rising edge;
// ready never depends on the same requester's valid, and valid may change
// freely while not accepted.
module lane_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    input  logic             c_valid,
    input  logic [WIDTH-1:0] c_data,
    input  logic             c_last,
    output logic             c_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic [7:0]       pkt_count
);

    typedef enum logic [1:0] {LANE_A = 2'd0, LANE_B = 2'd1, LANE_C = 2'd2} lane_t;
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    // All control state in one struct so checkers can bind to ctrl_q directly.
    typedef struct packed {
        state_t state;
        lane_t  owner;
        lane_t  ptr;
    } ctrl_t;

    ctrl_t ctrl_q, ctrl_d;

    function automatic lane_t lane_next(input lane_t l);
        case (l)
            LANE_A:  return LANE_B;
            LANE_B:  return LANE_C;
            default: return LANE_A;
        endcase
    endfunction

    function automatic logic lane_valid(input lane_t l, input logic [2:0] v);
        case (l)
            LANE_A:  return v[0];
            LANE_B:  return v[1];
            default: return v[2];
        endcase
    endfunction

    logic [2:0]       req_valid;
    lane_t            search1, search2;
    lane_t            grant;
    logic             grant_vld;
    logic             space;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic             accept;

    assign req_valid = {c_valid, b_valid, a_valid};
    assign search1   = lane_next(ctrl_q.ptr);
    assign search2   = lane_next(search1);

    // Grant: the owner while locked, else first valid requester from ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant     = ctrl_q.ptr;
        if (ctrl_q.state == LOCKED) begin
            grant_vld = 1'b1;
            grant     = ctrl_q.owner;
        end else if (lane_valid(ctrl_q.ptr, req_valid)) begin
            grant_vld = 1'b1;
            grant     = ctrl_q.ptr;
        end else if (lane_valid(search1, req_valid)) begin
            grant_vld = 1'b1;
            grant     = search1;
        end else if (lane_valid(search2, req_valid)) begin
            grant_vld = 1'b1;
            grant     = search2;
        end
    end

    // Mux the granted requester's beat toward the output buffer.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_last  = 1'b0;
        case (grant)
            LANE_A: begin
                sel_valid = a_valid;
                sel_data  = a_data;
                sel_last  = a_last;
            end
            LANE_B: begin
                sel_valid = b_valid;
                sel_data  = b_data;
                sel_last  = b_last;
            end
            default: begin
                sel_valid = c_valid;
                sel_data  = c_data;
                sel_last  = c_last;
            end
        endcase
    end

    // The buffer can take a beat when empty or draining this same cycle.
    assign space  = !out_valid || out_ready;
    assign accept = !rst && grant_vld && sel_valid && space;

    assign a_ready = !rst && grant_vld && (grant == LANE_A) && space;
    assign b_ready = !rst && grant_vld && (grant == LANE_B) && space;
    assign c_ready = !rst && grant_vld && (grant == LANE_C) && space;

    assign busy = (ctrl_q.state == LOCKED);

    // Next-state: lock on a non-final beat, release and rotate on a final beat.
    always_comb begin
        ctrl_d = ctrl_q;
        if (accept) begin
            if (sel_last) begin
                ctrl_d.state = IDLE;
                ctrl_d.ptr   = lane_next(grant);
            end else begin
                ctrl_d.state = LOCKED;
                ctrl_d.owner = grant;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '{state: IDLE, owner: LANE_A, ptr: LANE_A};
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    // Single-entry output buffer and completed-packet counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            pkt_count <= 8'd0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && sel_last) begin
                pkt_count <= pkt_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lane_rr_arbiter.sv
// Directed testbench for lane_rr_arbiter.
module tb_lane_rr_arbiter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             a_valid, b_valid, c_valid;
    logic [WIDTH-1:0] a_data, b_data, c_data;
    logic             a_last, b_last, c_last;
    logic             a_ready, b_ready, c_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic             busy;
    logic [7:0]       pkt_count;

    int n_pass  = 0;
    int n_total = 0;

    lane_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .c_valid   (c_valid),
        .c_data    (c_data),
        .c_last    (c_last),
        .c_ready   (c_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        c_valid = 1'b0; c_data = '0; c_last = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        out_ready = 1'b1;
        rst = 1'b1;
        a_valid = 1'b1;
        tick();
        settle();
        n_total++;
        if (a_ready !== 1'b0) $display("FAIL reset_ready: got %0b want 0", a_ready); else n_pass++;
        tick();
        rst = 1'b0;
        a_valid = 1'b0;
        settle();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else n_pass++;
        n_total++;
        if (out_data !== 8'h00) $display("FAIL reset_out_data: got %0h want 00", out_data); else n_pass++;
        n_total++;
        if (out_last !== 1'b0) $display("FAIL reset_out_last: got %0b want 0", out_last); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
        n_total++;
        if (pkt_count !== 8'd0) $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); else n_pass++;
    endtask

    // All three valid, single-beat packets: grants rotate a, b, c, a.
    task automatic test_round_robin();
        a_valid = 1'b1; a_data = 8'hA1; a_last = 1'b1;
        b_valid = 1'b1; b_data = 8'hB1; b_last = 1'b1;
        c_valid = 1'b1; c_data = 8'hC1; c_last = 1'b1;
        out_ready = 1'b1;
        settle();
        n_total++;
        if ({a_ready, b_ready, c_ready} !== 3'b100) $display("FAIL rr_grant_a: got %b want 100", {a_ready, b_ready, c_ready}); else n_pass++;
        tick();
        settle();
        n_total++;
        if (out_data !== 8'hA1 || out_valid !== 1'b1) $display("FAIL rr_out_a: got %0h/%0b want a1/1", out_data, out_valid); else n_pass++;
        n_total++;
        if ({a_ready, b_ready, c_ready} !== 3'b010) $display("FAIL rr_grant_b: got %b want 010", {a_ready, b_ready, c_ready}); else n_pass++;
        tick();
        settle();
        n_total++;
        if (out_data !== 8'hB1) $display("FAIL rr_out_b: got %0h want b1", out_data); else n_pass++;
        n_total++;
        if ({a_ready, b_ready, c_ready} !== 3'b001) $display("FAIL rr_grant_c: got %b want 001", {a_ready, b_ready, c_ready}); else n_pass++;
        tick();
        settle();
        n_total++;
        if (out_data !== 8'hC1) $display("FAIL rr_out_c: got %0h want c1", out_data); else n_pass++;
        n_total++;
        if (pkt_count !== 8'd3) $display("FAIL rr_pkt_count: got %0d want 3", pkt_count); else n_pass++;
        n_total++;
        if ({a_ready, b_ready, c_ready} !== 3'b100) $display("FAIL rr_grant_a_again: got %b want 100", {a_ready, b_ready, c_ready}); else n_pass++;
        clear_inputs();
        tick();
        settle();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL rr_drain: got %0b want 0", out_valid); else n_pass++;
    endtask

    // a holds the lane for a 3-beat packet while b waits.
    task automatic test_lock();
        logic [7:0] beats [3];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
        b_valid = 1'b1; b_data = 8'hB2; b_last = 1'b1;
        a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_data = beats[i];
            a_last = (i == 2);
            settle();
            n_total++;
            if (a_ready !== 1'b1 || b_ready !== 1'b0) $display("FAIL lock_ready_beat%0d: got a=%0b b=%0b want a=1 b=0", i, a_ready, b_ready); else n_pass++;
            n_total++;
            if (busy !== (i != 0)) $display("FAIL lock_busy_beat%0d: got %0b want %0b", i, busy, (i != 0)); else n_pass++;
            tick();
            settle();
            n_total++;
            if (out_data !== beats[i]) $display("FAIL lock_out_beat%0d: got %0h want %0h", i, out_data, beats[i]); else n_pass++;
        end
        a_valid = 1'b0;
        settle();
        n_total++;
        if (busy !== 1'b0 || out_last !== 1'b1) $display("FAIL lock_release: got busy=%0b last=%0b want 0/1", busy, out_last); else n_pass++;
        n_total++;
        if (b_ready !== 1'b1) $display("FAIL lock_b_next: got %0b want 1", b_ready); else n_pass++;
        n_total++;
        if (pkt_count !== 8'd4) $display("FAIL lock_pkt_count: got %0d want 4", pkt_count); else n_pass++;
        tick();
        settle();
        n_total++;
        if (out_data !== 8'hB2) $display("FAIL lock_b_out: got %0h want b2", out_data); else n_pass++;
        clear_inputs();
        tick();
    endtask

    // Downstream stalls with 0x5A buffered; everything must freeze.
    task automatic test_backpressure();
        c_valid = 1'b1; c_data = 8'h5A; c_last = 1'b1;
        settle();
        n_total++;
        if (c_ready !== 1'b1) $display("FAIL bp_c_ready: got %0b want 1", c_ready); else n_pass++;
        tick();
        clear_inputs();
        out_ready = 1'b0;
        a_valid = 1'b1; a_data = 8'h61; a_last = 1'b1;
        b_valid = 1'b1; b_data = 8'h62; b_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_total++;
            if (out_valid !== 1'b1 || out_data !== 8'h5A) $display("FAIL bp_hold_cyc%0d: got %0b/%0h want 1/5a", i, out_valid, out_data); else n_pass++;
            n_total++;
            if ({a_ready, b_ready, c_ready} !== 3'b000) $display("FAIL bp_ready_cyc%0d: got %b want 000", i, {a_ready, b_ready, c_ready}); else n_pass++;
            tick();
        end
        out_ready = 1'b1;
        settle();
        n_total++;
        if ({a_ready, b_ready, c_ready} !== 3'b100) $display("FAIL bp_release: got %b want 100", {a_ready, b_ready, c_ready}); else n_pass++;
        tick();
        settle();
        n_total++;
        if (out_data !== 8'h61 || pkt_count !== 8'd7) $display("FAIL bp_after: got %0h/%0d want 61/7", out_data, pkt_count); else n_pass++;
        clear_inputs();
        tick();
    endtask

    // Owner drops valid mid-packet; c must stay stalled.
    task automatic test_owner_stall();
        a_valid = 1'b1; a_data = 8'hA7; a_last = 1'b0;
        settle();
        n_total++;
        if (a_ready !== 1'b1) $display("FAIL stall_a_first: got %0b want 1", a_ready); else n_pass++;
        tick();
        a_valid = 1'b0;
        c_valid = 1'b1; c_data = 8'hCC; c_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            n_total++;
            if (c_ready !== 1'b0 || busy !== 1'b1) $display("FAIL stall_cyc%0d: got c_ready=%0b busy=%0b want 0/1", i, c_ready, busy); else n_pass++;
            tick();
        end
        a_valid = 1'b1; a_data = 8'hA8; a_last = 1'b1;
        settle();
        n_total++;
        if (a_ready !== 1'b1 || c_ready !== 1'b0) $display("FAIL stall_resume: got a=%0b c=%0b want 1/0", a_ready, c_ready); else n_pass++;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b1; b_data = 8'hB8; b_last = 1'b1;
        settle();
        n_total++;
        if (out_data !== 8'hA8 || busy !== 1'b0) $display("FAIL stall_complete: got %0h/%0b want a8/0", out_data, busy); else n_pass++;
        n_total++;
        if ({a_ready, b_ready, c_ready} !== 3'b010) $display("FAIL stall_ptr_b: got %b want 010", {a_ready, b_ready, c_ready}); else n_pass++;
        b_valid = 1'b0;
        settle();
        n_total++;
        if ({a_ready, b_ready, c_ready} !== 3'b001) $display("FAIL stall_ptr_c: got %b want 001", {a_ready, b_ready, c_ready}); else n_pass++;
        clear_inputs();
        tick();
    endtask

    // Reset while a owns the lane and the buffer is full.
    task automatic test_reset_mid();
        a_valid = 1'b1; a_data = 8'h71; a_last = 1'b0;
        tick();
        out_ready = 1'b0;
        a_data = 8'h72;
        settle();
        n_total++;
        if (busy !== 1'b1 || out_valid !== 1'b1) $display("FAIL rmid_pre: got busy=%0b valid=%0b want 1/1", busy, out_valid); else n_pass++;
        rst = 1'b1;
        out_ready = 1'b1;
        settle();
        n_total++;
        if (a_ready !== 1'b0) $display("FAIL rmid_ready_in_rst: got %0b want 0", a_ready); else n_pass++;
        tick();
        rst = 1'b0;
        clear_inputs();
        c_valid = 1'b1; c_data = 8'hC7; c_last = 1'b1;
        settle();
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || pkt_count !== 8'd0) $display("FAIL rmid_cleared: got valid=%0b busy=%0b cnt=%0d want 0/0/0", out_valid, busy, pkt_count); else n_pass++;
        n_total++;
        if (c_ready !== 1'b1) $display("FAIL rmid_c_grant: got %0b want 1", c_ready); else n_pass++;
        tick();
        settle();
        n_total++;
        if (out_data !== 8'hC7 || pkt_count !== 8'd1) $display("FAIL rmid_c_out: got %0h/%0d want c7/1", out_data, pkt_count); else n_pass++;
        clear_inputs();
        tick();
    endtask

    // 256 single-beat packets from a fresh reset: counter wraps to 0.
    task automatic test_wrap();
        do_reset();
        a_valid = 1'b1; a_data = 8'h0A; a_last = 1'b1;
        b_valid = 1'b1; b_data = 8'h0B; b_last = 1'b1;
        c_valid = 1'b1; c_data = 8'h0C; c_last = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        settle();
        n_total++;
        if (pkt_count !== 8'd255) $display("FAIL wrap_255: got %0d want 255", pkt_count); else n_pass++;
        tick();
        settle();
        n_total++;
        if (pkt_count !== 8'd0) $display("FAIL wrap_0: got %0d want 0", pkt_count); else n_pass++;
        n_total++;
        if (out_data !== 8'h0A) $display("FAIL wrap_last_owner: got %0h want 0a", out_data); else n_pass++;
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        out_ready = 1'b1;
        rst = 1'b1;
        test_reset();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_owner_stall();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
